// File: rtl/crc_stream_codec_if.sv
// Handshake/bus bundle for crc_stream_codec: request side (mode/data_in) and result side (data_out/err).
// SYNDROME_OUT_EN adds the syndrome signal to the bundle.
interface crc_stream_codec_if #(
  parameter int N = 64,
  parameter int K = 40
);
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] data_out;
  logic         err;
`ifdef SYNDROME_OUT_EN
  logic [N-K-1:0] syndrome;

  modport master (output mode, in_valid, data_in, out_ready,
                  input  in_ready, out_valid, data_out, err, syndrome);
  modport slave  (input  mode, in_valid, data_in, out_ready,
                  output in_ready, out_valid, data_out, err, syndrome);
`else
  modport master (output mode, in_valid, data_in, out_ready,
                  input  in_ready, out_valid, data_out, err);
  modport slave  (input  mode, in_valid, data_in, out_ready,
                  output in_ready, out_valid, data_out, err);
`endif
endinterface

// File: rtl/crc_stream_codec.sv
// Polynomial-division CRC encoder/checker, BPC bits per clock, valid/ready on both sides.
// Optional SYNDROME_OUT_EN exposes the final remainder alongside err.
module crc_stream_codec #(
  parameter int             N   = 64,
  parameter int             K   = 40,
  parameter logic [N-K-1:0] GEN = 24'h864CFB,
  parameter int             BPC = 1
) (
  input logic clk,
  input logic rst,
  crc_stream_codec_if.slave s
);
  localparam int R  = N - K;
  localparam int CK = K / BPC;
  localparam int CN = N / BPC;
  localparam int CW = $clog2(CN + 1);

  if (!(N > K))      begin : g_chk_nk  $error("N must exceed K"); end
  if (!(K >= 1))     begin : g_chk_k   $error("K must be at least 1"); end
  if (!(R >= 2))     begin : g_chk_r   $error("R must be at least 2"); end
  if (K % BPC != 0)  begin : g_chk_kb  $error("K must be a multiple of BPC"); end
  if (N % BPC != 0)  begin : g_chk_nb  $error("N must be a multiple of BPC"); end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, last;
  logic [N-1:0]  sh, word, data_out_q;
  logic [R-1:0]  rem;
  logic          md, err_q, accept;
`ifdef SYNDROME_OUT_EN
  logic [R-1:0]  syn_q;
`endif

  // One clock of division: BPC serial LFSR steps, MSB of the chunk first.
  function automatic logic [R-1:0] div_step(logic [R-1:0] r_in, logic [BPC-1:0] b);
    logic [R-1:0] r;
    logic         fb;
    r = r_in;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = r[R-1] ^ b[i];
      r  = {r[R-2:0], 1'b0} ^ (fb ? GEN : '0);
    end
    return r;
  endfunction

  assign accept = s.in_valid & s.in_ready;
  assign last   = md ? CW'(CN) : CW'(CK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (accept)      st_nxt = SHIFT;
      SHIFT:   if (cnt == last) st_nxt = DONE;
      DONE:    if (s.out_ready) st_nxt = IDLE;
      default:                  st_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    case (st)
      IDLE:    s.in_ready  = rst;
      DONE:    s.out_valid = 1'b1;
      default: ;
    endcase
  end

  // SHIFT runs last+1 clocks: 'last' division steps, then one clock to register the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      sh         <= '0;
      word       <= '0;
      md         <= 1'b0;
      rem        <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
`ifdef SYNDROME_OUT_EN
      syn_q      <= '0;
`endif
    end else if (accept) begin
      word <= s.data_in;
      md   <= s.mode;
      sh   <= s.mode ? s.data_in : {s.data_in[K-1:0], {R{1'b0}}};
      rem  <= '0;
      cnt  <= '0;
    end else if (st == SHIFT) begin
      if (cnt != last) begin
        rem <= div_step(rem, sh[N-1 -: BPC]);
        sh  <= sh << BPC;
        cnt <= cnt + 1'b1;
      end else begin
        data_out_q <= md ? {{R{1'b0}}, word[N-1:R]} : {word[K-1:0], rem};
        err_q      <= md & (|rem);
`ifdef SYNDROME_OUT_EN
        syn_q      <= rem;
`endif
      end
    end
  end

  assign s.data_out = data_out_q;
  assign s.err      = err_q;
`ifdef SYNDROME_OUT_EN
  assign s.syndrome = syn_q;
`endif
endmodule
